// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 select datapath blocks.
package mux_pkg;

  localparam int unsigned MUX_MAX_IN = 16;
  localparam int unsigned DATA_W     = 32;

  // Select width for an n-way mux; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return int'($clog2(n));
  endfunction

endpackage

// File: rtl/mux_nin1_comb.sv
// Combinational N-to-1 select. With MUX_NIN1_RANGE_CHECK_EN an out-of-range select
// yields zero data and raises o_oor; otherwise it falls back to channel 0.
module mux_nin1_comb
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned N_IN  = 4,
  localparam int unsigned SEL_W = sel_width(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] i_dat,
  input  logic [SEL_W-1:0]      i_sel,
  output logic [WIDTH-1:0]      o_dat
`ifdef MUX_NIN1_RANGE_CHECK_EN
  ,
  output logic                  o_oor
`endif
);

  always_comb begin
`ifdef MUX_NIN1_RANGE_CHECK_EN
    o_dat = '0;
`else
    o_dat = i_dat[WIDTH-1:0];
`endif
    for (int k = 0; k < int'(N_IN); k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_dat = i_dat[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MUX_NIN1_RANGE_CHECK_EN
  // Only reachable when N_IN is not a power of two.
  assign o_oor = (32'(i_sel) >= N_IN);
`endif

endmodule

// File: rtl/mux_nin1_pipe.sv
// Pipelined N-to-1 select with a one-entry valid/ready output register and a wrapping
// accepted-transfer counter. Optional range checking via MUX_NIN1_RANGE_CHECK_EN.
module mux_nin1_pipe
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned SEL_W = sel_width(N_IN)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_IN*WIDTH-1:0] i_dat,
  input  logic [SEL_W-1:0]      i_control,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [WIDTH-1:0]      o_dat,
  output logic [SEL_W-1:0]      o_sel,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CNT_W-1:0]      o_cnt
`ifdef MUX_NIN1_RANGE_CHECK_EN
  ,
  output logic                  o_err
`endif
);

  logic [WIDTH-1:0] r_dat;
  logic [SEL_W-1:0] r_sel;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_acc;
  logic [WIDTH-1:0] w_sel_dat;

  // The register frees up in the same cycle the downstream consumes it.
  assign o_ready = !r_valid || i_ready;
  assign w_acc   = i_valid && o_ready;

`ifdef MUX_NIN1_RANGE_CHECK_EN
  logic w_oor;
  logic r_err;

  mux_nin1_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_comb (
    .i_dat (i_dat),
    .i_sel (i_control),
    .o_dat (w_sel_dat),
    .o_oor (w_oor)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_acc && w_oor) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  mux_nin1_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_comb (
    .i_dat (i_dat),
    .i_sel (i_control),
    .o_dat (w_sel_dat)
  );
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dat   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_acc) begin
        r_dat   <= w_sel_dat;
        r_sel   <= i_control;
        r_valid <= 1'b1;
        r_cnt   <= r_cnt + CNT_W'(1);
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_dat   = r_dat;
  assign o_sel   = r_sel;
  assign o_valid = r_valid;
  assign o_cnt   = r_cnt;

endmodule

// File: tb/tb_mux_nin1_pipe.sv
// Scoreboard bench for mux_nin1_pipe: a 4-input instance under directed and random
// traffic, plus a 3-input instance exercising the out-of-range select.
module tb_mux_nin1_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned N3 = 3;
`ifdef MUX_NIN1_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N*W-1:0] i_dat;
  logic [SW-1:0] i_control;
  logic          i_valid, i_ready;
  logic          o_ready, o_valid;
  logic [W-1:0]  o_dat;
  logic [SW-1:0] o_sel;
  logic [CW-1:0] o_cnt;

  logic [N3*W-1:0] d3_dat;
  logic [1:0]      d3_control;
  logic            d3_valid, d3_ready;
  logic            d3_o_ready, d3_o_valid;
  logic [W-1:0]    d3_o_dat;
  logic [1:0]      d3_o_sel;
  logic [15:0]     d3_o_cnt;
`ifdef MUX_NIN1_RANGE_CHECK_EN
  logic            o_err, d3_o_err;
`endif

  always #5 clk = ~clk;

  mux_nin1_pipe #(.WIDTH(W), .N_IN(N), .CNT_W(CW)) u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_dat     (i_dat),
    .i_control (i_control),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_dat     (o_dat),
    .o_sel     (o_sel),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_cnt     (o_cnt)
`ifdef MUX_NIN1_RANGE_CHECK_EN
    ,
    .o_err     (o_err)
`endif
  );

  mux_nin1_pipe #(.WIDTH(W), .N_IN(N3), .CNT_W(16)) u_dut3 (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_dat     (d3_dat),
    .i_control (d3_control),
    .i_valid   (d3_valid),
    .o_ready   (d3_o_ready),
    .o_dat     (d3_o_dat),
    .o_sel     (d3_o_sel),
    .o_valid   (d3_o_valid),
    .i_ready   (d3_ready),
    .o_cnt     (d3_o_cnt)
`ifdef MUX_NIN1_RANGE_CHECK_EN
    ,
    .o_err     (d3_o_err)
`endif
  );

  typedef struct {
    logic [W-1:0]  dat;
    logic [SW-1:0] sel;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] chans[N];
  int           n_pass = 0;
  int           n_total = 0;
  bit           mon_en = 1'b0;
  bit           m_valid = 1'b0;
  int           m_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One cycle of stimulus; the model tracks occupancy and count, and queues the word.
  task automatic step(input bit v, input int ctrl, input bit rdy);
    bit   acc;
    exp_t e;
    for (int k = 0; k < int'(N); k++) i_dat[k*W +: W] = chans[k];
    i_valid   = v;
    i_control = SW'(ctrl);
    i_ready   = rdy;
    acc = v && (!m_valid || rdy);
    if (acc) begin
      e.dat = chans[ctrl];
      e.sel = SW'(ctrl);
      q.push_back(e);
    end
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1;
      m_cnt   = (m_cnt + 1) % (1 << CW);
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      check("ready", o_ready, !m_valid || i_ready);
      check("valid", o_valid, m_valid);
      check("cnt", o_cnt, m_cnt);
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL pop: output consumed with no expected word, got 0x%0h", o_dat);
        end else begin
          e = q.pop_front();
          check("dat", o_dat, e.dat);
          check("sel", o_sel, e.sel);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    i_dat = '0; i_control = '0; i_valid = 1'b0; i_ready = 1'b0;
    d3_dat = '0; d3_control = '0; d3_valid = 1'b0; d3_ready = 1'b1;
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_dat", o_dat, 0);
    check("rst_cnt", o_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    chans[0] = 32'd20; chans[1] = 32'd10; chans[2] = 32'hA5A5A5A5; chans[3] = 32'd7;
    step(1, 1, 1);
    step(0, 0, 1);
    for (int k = 0; k < 4; k++) step(1, k, 1);
    step(0, 0, 1);
    // Backpressure: hold channel 2 while channel 3 waits.
    step(1, 2, 1);
    for (int k = 0; k < 3; k++) step(1, 3, 0);
    step(1, 3, 1);
    step(0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < int'(N); k++) chans[k] = $urandom;
      step(($urandom % 4) != 0, int'($urandom % N), ($urandom % 10) < 7);
    end
    step(0, 0, 1);
    step(0, 0, 1);
    check("queue_drained", q.size(), 0);

    // Counter wrap: 17 accepts from a cleared counter.
    rst = 1'b1; #1; rst = 1'b0;
    q.delete(); m_valid = 1'b0; m_cnt = 0;
    for (int i = 0; i < 17; i++) step(1, i % 4, 1);
    check("cnt_wrap", o_cnt, 1);
    step(0, 0, 1);

    // Asynchronous reset with a word held under stall.
    chans[0] = 32'hDEADBEEF;
    step(1, 0, 0);
    step(1, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_dat", o_dat, 0);
    check("arst_cnt", o_cnt, 0);
    check("arst_ready", o_ready, 1);
`ifdef MUX_NIN1_RANGE_CHECK_EN
    check("arst_err", o_err, 0);
`endif
    q.delete(); m_valid = 1'b0; m_cnt = 0;
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 2, 1);
    step(0, 0, 1);

    // Out-of-range select on the 3-input instance.
    d3_dat = {32'h33, 32'h22, 32'h11};
    d3_valid = 1'b1; d3_control = 2'd3;
    @(posedge clk); #1;
    check("oor_dat", d3_o_dat, RC ? 32'h0 : 32'h11);
    check("oor_sel", d3_o_sel, 3);
    check("oor_valid", d3_o_valid, 1);
    check("oor_cnt", d3_o_cnt, 1);
`ifdef MUX_NIN1_RANGE_CHECK_EN
    check("oor_err", d3_o_err, 1);
`endif
    d3_control = 2'd1;
    @(posedge clk); #1;
    check("d3_dat", d3_o_dat, 32'h22);
    check("d3_sel", d3_o_sel, 1);
    check("d3_cnt", d3_o_cnt, 2);
`ifdef MUX_NIN1_RANGE_CHECK_EN
    check("err_sticky", d3_o_err, 1);
    check("err_main", o_err, 0);
`endif
    d3_valid = 1'b0;
    @(posedge clk); #1;
    check("d3_drain", d3_o_valid, 0);
    check("d3_hold", d3_o_dat, 32'h22);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_nin1_pipe.md
Name: mux_nin1_pipe

Overview:
Parametrised N-input, WIDTH-bit selector with a registered output stage and valid/ready flow control. It replaces the combinational two-input mux wherever datapath select must be pipelined, e.g. ALU-source or writeback-source select in a pipelined core. It adds backpressure, a one-entry output register, and a wrapping accepted-transfer counter.

Parameters:
- WIDTH, 32, data width per input channel.
- N_IN, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(N_IN), select width; derived, not overridden.
- CNT_W, 16, width of the accepted-transfer counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high. Clears all state immediately.
- i_dat  in  N_IN*WIDTH  packed inputs; channel k occupies [k*WIDTH +: WIDTH].
- i_control  in  SEL_W  channel select, sampled on accept.
- i_valid  in  1  upstream offers a word.
- o_ready  out  1  block can accept this cycle.
- o_dat  out  WIDTH  registered selected data.
- o_sel  out  SEL_W  registered select that produced o_dat.
- o_valid  out  1  o_dat holds an unconsumed word.
- i_ready  in  1  downstream consumes o_dat when o_valid=1.
- o_cnt  out  CNT_W  number of accepted transfers, mod 2^CNT_W.
- o_err  out  1  sticky out-of-range select flag; exists only with the macro defined.

Behaviour:
- Reset (asynchronous, while i_rst=1):
  - o_dat=0, o_sel=0, o_valid=0, o_cnt=0, o_err=0.
  - o_ready is 1 during and after reset.
- o_ready is combinational: o_ready = !o_valid || i_ready. It has no dependence on i_valid.
- Accept condition: acc = i_valid && o_ready.
  - On acc, the next edge loads o_dat <= channel[i_control] and o_sel <= i_control.
  - On acc, o_valid <= 1 and o_cnt <= o_cnt+1; o_cnt wraps from 2^CNT_W-1 to 0.
- Latency: exactly one cycle from accept to o_valid=1.
- Throughput: one word per cycle when i_ready is held at 1.
- Drain: if o_valid && i_ready && !acc, then o_valid <= 0. o_dat and o_sel hold their last values.
- Stall: if o_valid && !i_ready, then o_ready=0, and o_dat, o_sel and o_valid hold unchanged.
- Simultaneous consume and accept (o_valid=1, i_ready=1, i_valid=1): the new word replaces the old one in the same edge and o_valid stays 1.
- i_dat and i_control are don't-care when acc=0. No state changes in that case.
- Reset asserted mid-transfer: the held word is discarded, o_valid drops immediately, and the counter clears.
- Out-of-range select (i_control >= N_IN; possible only when N_IN is not a power of 2): see Optional Feature.

Optional Feature:
- Macro: MUX_NIN1_RANGE_CHECK_EN.
- Defined:
  - An accepted out-of-range select loads o_dat=0 and o_sel=i_control.
  - It sets o_err=1, which stays sticky until reset.
  - The transfer still counts in o_cnt.
- Undefined:
  - o_err port is absent.
  - An out-of-range select loads channel 0 data.
  - No error is recorded.

Decomposition:
- Shared package mux_pkg holds:
  - MUX_MAX_IN = 16.
  - The default-width constant DATA_W = 32.
  - A function sel_width(n) returning $clog2(n), with a minimum of 1.
- Natural sub-module: mux_nin1_comb.
  - Purely combinational N-to-1 select with range handling.
  - Instantiated once, feeding the output register.
  - Reusable elsewhere in the datapath.

Test Plan:
- Reset check: assert i_rst mid-cycle with o_valid=1 and o_dat=0xDEADBEEF -> o_valid, o_dat, o_cnt and o_err are 0 immediately without a clock edge; o_ready=1.
- Basic select: N_IN=4, channels = 20, 10, 0xA5A5A5A5, 7; i_control=1, i_valid=1, i_ready=1 -> after one edge o_dat=10, o_sel=1, o_valid=1, o_cnt=1.
- Streaming: i_control cycles through 0,1,2,3 on consecutive cycles with i_ready=1 -> o_dat sequence 20, 10, 0xA5A5A5A5, 7 with no bubbles; o_cnt=4.
- Backpressure: load channel 2, then i_ready=0 for 3 cycles while i_valid=1 with i_control=3 -> o_ready=0, and o_dat stays 0xA5A5A5A5. When i_ready rises, that same edge loads 7.
- Counter wrap: CNT_W=4, perform 17 accepts -> o_cnt=1.
- Range check: N_IN=3, i_control=3 accepted -> with the macro defined, o_dat=0, o_err=1 and sticky across later valid transfers; without the macro, o_dat = channel 0 value.
